// File: rtl/tts8_pkg.sv
// Shared types and constants for the front-panel/CPU RAM access path.
package tts8_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   localparam logic [7:0] PROG_COUNT_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PWRITE = 2'd1,
      CLEAR  = 2'd2,
      RUN    = 2'd3
   } state_t;

endpackage

// File: rtl/ram_access_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for a raw panel input, plus a one-cycle rising-edge pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic meta;
   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta  <= 1'b0;
         level <= 1'b0;
         prev  <= 1'b0;
      end else begin
         meta  <= din;
         level <= meta;
         prev  <= level;
      end
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/ram_access_ctrl.sv
// Arbitrates the 16x8 RAM write/read port between the front panel and the CPU, with sequenced clear.
// Build option AUTO_INC_EN: panel address comes from an internal auto-incrementing pointer instead of sw_addr.
module ram_access_ctrl
   import tts8_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load_btn,
   input  logic              clr_btn,
   input  logic [ADDR_W-1:0] sw_addr,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [7:0]        prog_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] panel_addr;
   logic              start_lvl;
   logic              start_rise_unused;
   logic              load_lvl_unused;
   logic              clr_lvl_unused;
   logic              load_rise;
   logic              clr_rise;

   btn_sync_edge u_start_sync (
      .clk  (clk),
      .reset(reset),
      .din  (start),
      .level(start_lvl),
      .rise (start_rise_unused)
   );

   btn_sync_edge u_load_sync (
      .clk  (clk),
      .reset(reset),
      .din  (load_btn),
      .level(load_lvl_unused),
      .rise (load_rise)
   );

   btn_sync_edge u_clr_sync (
      .clk  (clk),
      .reset(reset),
      .din  (clr_btn),
      .level(clr_lvl_unused),
      .rise (clr_rise)
   );

`ifdef AUTO_INC_EN
   logic [ADDR_W-1:0] prog_ptr;
   logic              sw_addr_unused;
   assign sw_addr_unused = ^sw_addr;
   assign panel_addr     = prog_ptr;
`else
   assign panel_addr = sw_addr;
`endif

   // Edges seen outside IDLE are simply not acted on; the detector keeps running so nothing queues.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         prog_count <= '0;
`ifdef AUTO_INC_EN
         prog_ptr   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (clr_rise) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end else if (load_rise) begin
                  state <= PWRITE;
               end else if (start_lvl) begin
                  state <= RUN;
               end
            end
            PWRITE: begin
               state <= IDLE;
               if (prog_count != PROG_COUNT_MAX)
                  prog_count <= prog_count + 8'd1;
`ifdef AUTO_INC_EN
               prog_ptr <= prog_ptr + 1'b1;
`endif
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                  state      <= IDLE;
                  prog_count <= '0;
`ifdef AUTO_INC_EN
                  prog_ptr   <= '0;
`endif
               end
            end
            RUN: begin
               if (!start_lvl)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      cpu_ready = 1'b0;
      busy      = 1'b0;
      mem_addr  = panel_addr;
      mem_wdata = sw_data;
      case (state)
         PWRITE: mem_we = 1'b1;
         CLEAR: begin
            mem_we    = 1'b1;
            busy      = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = '0;
         end
         RUN: begin
            cpu_ready = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_req & cpu_we;
         end
         default: ;
      endcase
      // Address/data are combinational from the sources, so force them to zero while reset is held.
      if (reset) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: stimulus queues expected RAM writes, a monitor pops them.
module tb_ram_access_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, load_btn, clr_btn;
   logic [AW-1:0] sw_addr, cpu_addr, mem_addr;
   logic [DW-1:0] sw_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
   logic          cpu_req, cpu_we, cpu_ready, mem_we, busy;
   logic [7:0]    prog_count;

   always #5 clk = ~clk;

   ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .load_btn(load_btn), .clr_btn(clr_btn),
      .sw_addr(sw_addr), .sw_data(sw_data), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .prog_count(prog_count)
   );

   // Behavioural RAM attached to the port.
   logic [DW-1:0] ram [DEPTH];
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_q[$];
   logic [DW-1:0] shadow [DEPTH];
   int            model_pc  = 0;
   int            model_ptr = 0;
   int            checks    = 0;
   int            failures  = 0;
   bit            mon_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({a, d});
      shadow[a] = d;
   endtask

   function automatic logic [AW-1:0] panel_target(input logic [AW-1:0] sw);
`ifdef AUTO_INC_EN
      return AW'(model_ptr);
`else
      return sw;
`endif
   endfunction

   // Monitor: every RAM write must match the next queued expectation.
   always @(negedge clk) begin : monitor
      wr_t w;
      if (mon_en && !reset && mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                     mem_addr, mem_wdata, $time);
         end else begin
            w = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(w.a));
            check("wr_data", 32'(mem_wdata), 32'(w.d));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic model_pwrite(input logic [AW-1:0] sw, input logic [DW-1:0] d);
      expect_wr(panel_target(sw), d);
      model_ptr = (model_ptr + 1) % DEPTH;
      if (model_pc < 255) model_pc++;
   endtask

   task automatic press_load(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
      step();
      sw_addr  = a;
      sw_data  = d;
      load_btn = 1'b1;
      model_pwrite(a, d);
      repeat (hold) step();
      load_btn = 1'b0;
      repeat (5) step();
      check("prog_count", 32'(prog_count), 32'(model_pc));
   endtask

   // with_load: load pressed on the same cycle as clear; mid_load: load pressed during the clear.
   task automatic press_clear(input bit with_load, input bit mid_load);
      int t;
      int n;
      step();
      clr_btn = 1'b1;
      if (with_load) begin
         sw_addr  = 4'($urandom_range(15));
         sw_data  = 8'($urandom_range(255));
         load_btn = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) expect_wr(AW'(i), '0);
      model_pc  = 0;
      model_ptr = 0;
      step();
      clr_btn  = 1'b0;
      load_btn = 1'b0;
      t = 0;
      while (!busy && t < 10) begin
         @(negedge clk);
         t++;
      end
      check("clear_started", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 40) begin
         n++;
         if (mid_load && n == 4) load_btn = 1'b1;
         if (n == 6) load_btn = 1'b0;
         @(negedge clk);
      end
      check("busy_cycles", 32'(n), 32'(DEPTH));
      repeat (6) step();
      check("prog_count_after_clear", 32'(prog_count), 32'd0);
      check("clear_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      step();
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      if (we) expect_wr(a, d);
      @(negedge clk);
      check("cpu_ready", 32'(cpu_ready), 32'd1);
      check("cpu_mem_we", 32'(mem_we), 32'(we));
      if (!we) check("cpu_rdata", 32'(cpu_rdata), 32'(shadow[a]));
      step();
      cpu_req = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      reset     = 1'b1;
      start     = 1'b0;
      load_btn  = 1'b0;
      clr_btn   = 1'b0;
      sw_addr   = 4'hA;
      sw_data   = 8'hFF;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 4'h3;
      cpu_wdata = 8'h77;
      #3;
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_prog_count", 32'(prog_count), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      repeat (3) step();
      reset  = 1'b0;
      mon_en = 1'b1;
      step();

      // Clear first so the RAM model holds known contents; a load press during the clear is dropped.
      press_clear(1'b0, 1'b1);

      // First-press latency: write appears on the 4th negedge after driving, i.e. 3 edges after sampling.
      step();
      sw_addr  = 4'd5;
      sw_data  = 8'hA7;
      load_btn = 1'b1;
      model_pwrite(4'd5, 8'hA7);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("load_latency_%0d", k), 32'(mem_we), 32'(k == 4));
      end
      step();
      load_btn = 1'b0;
      repeat (4) step();
      check("prog_count_first", 32'(prog_count), 32'd1);

      press_load(4'($urandom_range(15)), 8'($urandom_range(255)), 20);
      for (int i = 0; i < 8; i++)
         press_load(4'($urandom_range(15)), 8'($urandom_range(255)), int'($urandom_range(6, 1)));

      press_clear(1'b1, 1'b0);

      for (int i = 0; i < 6; i++)
         press_load(4'($urandom_range(15)), 8'($urandom_range(255)), int'($urandom_range(4, 1)));

      step();
      start = 1'b1;
      t = 0;
      while (!cpu_ready && t < 8) begin
         step();
         t++;
      end
      check("run_entered", 32'(cpu_ready), 32'd1);
      cpu_op(1'b1, 4'd9, 8'h3C);
      cpu_op(1'b0, 4'd9, 8'h00);
      for (int i = 0; i < 20; i++)
         cpu_op(1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));

      step();
      load_btn = 1'b1;
      repeat (3) step();
      load_btn = 1'b0;
      repeat (4) step();
      check("prog_count_run_load", 32'(prog_count), 32'(model_pc));

      for (int i = 0; i < DEPTH; i++) cpu_op(1'b0, AW'(i), 8'h00);
      step();
      start = 1'b0;
      repeat (4) step();
      check("run_exited", 32'(cpu_ready), 32'd0);

      // Reset part-way through a clear; remaining clear writes never happen, so the monitor stands down.
      mon_en = 1'b0;
      step();
      clr_btn = 1'b1;
      step();
      clr_btn = 1'b0;
      t = 0;
      while (!busy && t < 10) begin
         step();
         t++;
      end
      check("clear2_started", 32'(busy), 32'd1);
      repeat (7) @(posedge clk);
      #3;
      sw_addr = 4'hD;
      sw_data = 8'h5A;
      reset   = 1'b1;
      #1;
      check("midclr_mem_we", 32'(mem_we), 32'd0);
      check("midclr_busy", 32'(busy), 32'd0);
      check("midclr_cpu_ready", 32'(cpu_ready), 32'd0);
      check("midclr_prog_count", 32'(prog_count), 32'd0);
      check("midclr_mem_addr", 32'(mem_addr), 32'd0);
      check("midclr_mem_wdata", 32'(mem_wdata), 32'd0);
      step();
      reset     = 1'b0;
      model_pc  = 0;
      model_ptr = 0;
      step();
      mon_en = 1'b1;
      check("post_reset_busy", 32'(busy), 32'd0);

      press_load(4'd2, 8'hC4, 2);
      repeat (4) step();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
